// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues single-outstanding imem reads and
// buffers returned words in a 2-entry FIFO presented to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]  pc_q;
  logic [31:0]  inflight_pc_q;
  logic         outstanding_q;
  logic         drop_q;
  fetch_entry_t buf_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;

  logic         pop;
  logic         push;
  logic         rsp;
  logic         req_fire;
  logic [2:0]   occupancy;
  logic         unused_redirect_lsbs;
  fetch_entry_t head;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign instr_valid = count_q != 2'd0;
  assign pop = instr_valid && instr_ready;

  // Slots claimed after this cycle: buffered words plus the pending response.
  assign occupancy = {1'b0, count_q}
                   + {2'b00, outstanding_q}
                   - {2'b00, pop};

  assign imem_req_valid = !rst && !redirect
                       && (!outstanding_q || imem_rsp_valid)
                       && (occupancy <= 3'd1);
  assign imem_addr = pc_q;
  assign req_fire = imem_req_valid && imem_req_ready;

  assign rsp  = imem_rsp_valid && outstanding_q;
  assign push = rsp && !drop_q && !redirect;

  assign head     = buf_q[rd_ptr_q];
  assign instr    = head.instr;
  assign instr_pc = head.pc;
  assign opcode   = head.instr[6:0];
  assign func3    = head.instr[14:12];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= 32'h0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      if (redirect) begin
        pc_q <= {redirect_pc[31:2], 2'b00};
      end else if (req_fire) begin
        pc_q <= pc_q + 32'd4;
      end
      if (req_fire) begin
        inflight_pc_q <= pc_q;
      end
      if (req_fire) begin
        outstanding_q <= 1'b1;
      end else if (rsp) begin
        outstanding_q <= 1'b0;
      end
      // A response still in flight at redirect belongs to the old path.
      if (rsp) begin
        drop_q <= 1'b0;
      end else if (redirect && outstanding_q) begin
        drop_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q[0] <= '{instr: NOP, pc: 32'h0};
      buf_q[1] <= '{instr: NOP, pc: 32'h0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (redirect) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= '{instr: imem_rsp_data, pc: inflight_pc_q};
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with configurable latency, stream-level
// reference of request and delivery order, plus directed literal checks.
module tb_fetch_unit;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, rsp_valid, redirect;
  logic        instr_valid, instr_ready;
  logic [31:0] addr, rsp_data, redirect_pc, instr, instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;

  logic        w_req_valid, w_rsp_valid, w_instr_valid;
  logic [31:0] w_addr, w_rsp_data, w_instr, w_instr_pc;
  logic [6:0]  w_opcode;
  logic [2:0]  w_func3;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready),
    .imem_addr(addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .func3(func3)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_instr_valid), .instr_ready(1'b1),
    .instr(w_instr), .instr_pc(w_instr_pc),
    .opcode(w_opcode), .func3(w_func3)
  );

  typedef struct {
    int          due;
    logic [31:0] a;
  } mreq_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;
  mreq_t mq[$];
  logic [31:0] exp_req, exp_pop;
  logic [31:0] acc_log[$], pop_log[$];
  int          pop_cyc[$];
  logic [31:0] w_acc[$], w_pop[$], w_ins[$], w_fld[$];
  logic        w_pend;
  logic [31:0] w_pend_a;
  logic        p_redir, p_hold, p_req_hold;
  logic [31:0] p_instr, p_pc, p_addr;
  logic        s_req_valid, s_instr_valid;
  logic [31:0] s_addr, s_instr_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5013;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req_valid"}, 32'(req_valid), 32'h0);
    check({tag, "_addr"}, addr, 32'h0);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_instr_pc"}, instr_pc, 32'h0);
    check({tag, "_opcode"}, 32'(opcode), 32'h13);
    check({tag, "_func3"}, 32'(func3), 32'h0);
  endtask

  task automatic clear_model();
    exp_req = 32'h0;
    exp_pop = 32'h0;
    acc_log.delete();
    pop_log.delete();
    pop_cyc.delete();
    w_acc.delete();
    w_pop.delete();
    w_ins.delete();
    w_fld.delete();
    w_pend = 1'b0;
    p_redir = 1'b0;
    p_hold = 1'b0;
    p_req_hold = 1'b0;
  endtask

  task automatic step(input logic rst_v, input logic rdy, input logic ird,
                      input logic redir, input logic [31:0] tgt,
                      input logic mid_rst);
    logic acc, pop, had_rsp;
    logic [31:0] w;
    @(negedge clk);
    rst = rst_v;
    req_ready = rdy;
    instr_ready = ird;
    redirect = redir;
    redirect_pc = tgt;
    had_rsp = mq.size() > 0 && mq[0].due <= cyc;
    rsp_valid = had_rsp;
    rsp_data = had_rsp ? memf(mq[0].a) : 32'hDEAD_BEEF;
    w_rsp_valid = w_pend;
    w_rsp_data = w_pend ? memf(w_pend_a) : 32'hDEAD_BEEF;
    #1;
    acc = req_valid && req_ready;
    pop = instr_valid && instr_ready && !redirect;
    if (rst) begin
      check_reset_outs("rst");
      check("wrap_rst_addr", w_addr, WRAP_PC);
      clear_model();
    end else begin
      if (redirect) check("no_req_on_redirect", 32'(req_valid), 32'h0);
      if (p_redir) check("valid_low_after_redirect", 32'(instr_valid), 32'h0);
      if (p_hold) begin
        check("hold_valid", 32'(instr_valid), 32'h1);
        check("hold_instr", instr, p_instr);
        check("hold_pc", instr_pc, p_pc);
      end
      if (p_req_hold && req_valid) check("addr_hold", addr, p_addr);
      if (acc) begin
        check("req_addr", addr, exp_req);
        check("one_outstanding", 32'(mq.size() == 0 || had_rsp), 32'h1);
        if (!mid_rst) mq.push_back('{cyc + lat, addr});
        acc_log.push_back(addr);
        exp_req += 32'd4;
      end
      if (pop) begin
        w = memf(exp_pop);
        check("instr_pc", instr_pc, exp_pop);
        check("instr", instr, w);
        check("opcode", 32'(opcode), {25'b0, w[6:0]});
        check("func3", 32'(func3), {29'b0, w[14:12]});
        pop_log.push_back(instr_pc);
        pop_cyc.push_back(cyc);
        exp_pop += 32'd4;
      end
      if (redirect) begin
        exp_req = {tgt[31:2], 2'b00};
        exp_pop = {tgt[31:2], 2'b00};
      end
      p_redir = redirect;
      p_hold = instr_valid && !instr_ready && !redirect;
      p_instr = instr;
      p_pc = instr_pc;
      p_req_hold = req_valid && !req_ready && !redirect;
      p_addr = addr;
      s_req_valid = req_valid;
      s_addr = addr;
      s_instr_valid = instr_valid;
      s_instr_pc = instr_pc;
      if (w_req_valid) w_acc.push_back(w_addr);
      if (w_instr_valid) begin
        w_pop.push_back(w_instr_pc);
        w_ins.push_back(w_instr);
        w_fld.push_back({22'b0, w_func3, w_opcode});
      end
      w_pend = w_req_valid;
      w_pend_a = w_addr;
    end
    if (had_rsp) void'(mq.pop_front());
    if (mid_rst) begin
      #2 rst = 1'b1;
      #1;
      check_reset_outs("async_rst");
      clear_model();
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic run(input int n, input logic rdy, input logic ird);
    for (int i = 0; i < n; i++) step(1'b0, rdy, ird, 1'b0, 32'h0, 1'b0);
  endtask

  int t0, na, np;
  logic found;
  logic [31:0] wv;

  initial begin
    req_ready = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    rsp_valid = 1'b0;
    rsp_data = 32'h0;
    w_rsp_valid = 1'b0;
    w_rsp_data = 32'h0;
    clear_model();

    // Streaming with 1-cycle memory, plus the wrapping instance
    do_reset();
    lat = 1;
    t0 = cyc;
    run(8, 1'b1, 1'b1);
    check("t1_accepts", 32'(acc_log.size()), 32'd8);
    check("t1_pops", 32'(pop_log.size()), 32'd6);
    check("t1_first_pop_cycle", 32'(pop_cyc.size() > 0 ? pop_cyc[0] - t0 : -1), 32'd2);
    check("t1_req7", qat(acc_log, 7), 32'h1C);
    check("t1_pop5", qat(pop_log, 5), 32'h14);
    check("wrap_req0", qat(w_acc, 0), 32'hFFFF_FFF8);
    check("wrap_req1", qat(w_acc, 1), 32'hFFFF_FFFC);
    check("wrap_req2", qat(w_acc, 2), 32'h0000_0000);
    check("wrap_pop0", qat(w_pop, 0), 32'hFFFF_FFF8);
    check("wrap_pop2", qat(w_pop, 2), 32'h0000_0000);
    check("wrap_instr0", qat(w_ins, 0), memf(32'hFFFF_FFF8));
    check("wrap_instr2", qat(w_ins, 2), memf(32'h0));
    wv = memf(32'hFFFF_FFFC);
    check("wrap_fields1", qat(w_fld, 1), {22'b0, wv[14:12], wv[6:0]});

    // Backpressure for 5 cycles
    do_reset();
    lat = 1;
    run(4, 1'b1, 1'b1);
    run(2, 1'b1, 1'b0);
    check("bp_req_dropped", 32'(s_req_valid), 32'h0);
    check("bp_head_valid", 32'(s_instr_valid), 32'h1);
    check("bp_head_pc", s_instr_pc, 32'h8);
    run(3, 1'b1, 1'b0);
    check("bp_req_still_low", 32'(s_req_valid), 32'h0);
    check("bp_head_pc_late", s_instr_pc, 32'h8);
    run(6, 1'b1, 1'b1);
    check("bp_pops", 32'(pop_log.size()), 32'd8);
    check("bp_drain0", qat(pop_log, 2), 32'h8);
    check("bp_drain1", qat(pop_log, 3), 32'hC);
    check("bp_drain2", qat(pop_log, 4), 32'h10);

    // Redirect while the request to 0x10 is outstanding, 3-cycle memory
    do_reset();
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      run(1, 1'b1, 1'b1);
      found = acc_log.size() > 0 && acc_log[acc_log.size() - 1] == 32'h10;
    end
    check("rd_found_req_0x10", 32'(found), 32'h1);
    na = acc_log.size();
    np = pop_log.size();
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    run(14, 1'b1, 1'b1);
    check("rd_next_req", qat(acc_log, na), 32'h100);
    check("rd_next_pop", qat(pop_log, np), 32'h100);
    check("rd_after_pop", qat(pop_log, np + 1), 32'h104);

    // Redirect coinciding with a response, decode stalled
    do_reset();
    lat = 2;
    run(4, 1'b1, 1'b0);
    check("rr_accepts", 32'(acc_log.size()), 32'd2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
    check("rr_valid_in_redirect", 32'(s_instr_valid), 32'h1);
    np = pop_log.size();
    run(1, 1'b1, 1'b0);
    check("rr_empty_after", 32'(s_instr_valid), 32'h0);
    check("rr_req_next", 32'(s_req_valid), 32'h1);
    check("rr_req_addr", s_addr, 32'h200);
    run(6, 1'b1, 1'b1);
    check("rr_first_pop", qat(pop_log, np), 32'h200);

    // Asynchronous reset mid-stream with a request in flight
    do_reset();
    lat = 3;
    run(5, 1'b1, 1'b0);
    check("ar_pre_valid", 32'(s_instr_valid), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    lat = 1;
    run(5, 1'b1, 1'b1);
    check("ar_restart_req", qat(acc_log, 0), 32'h0);
    check("ar_restart_pop", qat(pop_log, 0), 32'h0);
    check("ar_restart_pop1", qat(pop_log, 1), 32'h4);

    // Mixed stalls and occasional redirects
    do_reset();
    lat = 2;
    for (int i = 0; i < 120; i++) begin
      step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0, $urandom, 1'b0);
    end
    check("mix_made_progress", 32'(pop_log.size() > 0), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
